// File: rtl/ntt_iter_core.sv
// ntt_iter_core
//   Iterative N-point number-theoretic transform. A single butterfly is
//   time-multiplexed over an in-place coefficient buffer. Forward NTT or
//   inverse NTT (with N^-1 scaling) is chosen per polynomial.
//
//   Flow: LOAD (N beats, bit-reversed write) -> CALC (LOG_N*N/2 butterflies,
//   one per cycle) -> DRAIN (N beats, natural order) -> LOAD.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   s_valid/s_ready       input coefficient handshake (ready only in LOAD)
//   s_data                input coefficient, natural order, reduced mod q
//   s_inverse             mode, sampled on beat 0 (1 = INTT)
//   m_valid/m_ready       output coefficient handshake (valid only in DRAIN)
//   m_data, m_last        output coefficient, last flag on coefficient N-1
//   busy                  high in CALC or DRAIN
module ntt_iter_core #(
    parameter int N          = 16,
    parameter int DATA_WIDTH = 16,
    parameter int MODULUS    = 17,
    parameter int ROOT       = 3,
    parameter int ROOT_INV   = 6,
    parameter int N_INV      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_inverse,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy
);
    localparam int DW    = DATA_WIDTH;
    localparam int AW    = $clog2(N);
    localparam int LOG_N = AW;
    localparam int SW    = (LOG_N > 1) ? $clog2(LOG_N) : 1;

    localparam logic [2*DW-1:0] Q_W   = (2*DW)'(MODULUS);
    localparam logic [DW:0]     Q_1   = (DW+1)'(MODULUS);
    localparam logic [DW-1:0]   Q_D   = DW'(MODULUS);
    localparam logic [DW-1:0]   NINV  = DW'(N_INV);
    localparam logic [AW-1:0]   LASTI = AW'(N-1);
    localparam logic [SW-1:0]   LASTS = SW'(LOG_N-1);

    typedef enum logic [1:0] {LOAD, CALC, DRAIN} state_t;

    function automatic logic [DW-1:0] mulmod(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [2*DW-1:0] p;
        p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        return DW'(p % Q_W);
    endfunction

    function automatic logic [DW-1:0] powmod(input int base, input int e);
        logic [DW-1:0] r;
        r = DW'(1);
        for (int i = 0; i < e; i++) r = mulmod(r, DW'(base));
        return r;
    endfunction

    // Per-stage twiddle step: wlen_s = R^(N/len), len = 2^(s+1).
    logic [DW-1:0] wlen_fwd [LOG_N];
    logic [DW-1:0] wlen_inv [LOG_N];
    for (genvar s = 0; s < LOG_N; s++) begin : g_tw
        localparam logic [DW-1:0] WF = powmod(ROOT,     N >> (s+1));
        localparam logic [DW-1:0] WI = powmod(ROOT_INV, N >> (s+1));
        assign wlen_fwd[s] = WF;
        assign wlen_inv[s] = WI;
    end

    state_t          state_q, state_d;
    logic [AW-1:0]   load_cnt_q, out_cnt_q, base_q, j_q;
    logic [SW-1:0]   st_q;
    logic [DW-1:0]   w_q;
    logic            inverse_q;
    logic [DW-1:0]   mem_q [N];

    logic [AW-1:0]   half, idx_u, idx_v, brev;
    logic [AW:0]     end_w;
    logic [DW-1:0]   u, v, t, wlen, s_red, sum_r, diff_r;
    logic [DW:0]     sum, diff;
    logic            grp_last, blk_last, bf_last;

    always_comb begin
        half     = AW'(1) << st_q;
        idx_u    = base_q + j_q;
        idx_v    = idx_u + half;
        end_w    = {1'b0, base_q} + ({1'b0, half} << 1);
        u        = mem_q[idx_u];
        v        = mem_q[idx_v];
        t        = mulmod(w_q, v);
        // u, t < q so one conditional subtract is a full reduction.
        sum      = {1'b0, u} + {1'b0, t};
        diff     = {1'b0, u} + Q_1 - {1'b0, t};
        sum_r    = (sum  >= Q_1) ? DW'(sum  - Q_1) : DW'(sum);
        diff_r   = (diff >= Q_1) ? DW'(diff - Q_1) : DW'(diff);
        wlen     = inverse_q ? wlen_inv[st_q] : wlen_fwd[st_q];
        grp_last = (j_q == half - AW'(1));
        blk_last = grp_last && (end_w == (AW+1)'(N));
        bf_last  = blk_last && (st_q == LASTS);
        s_red    = s_data % Q_D;
        brev     = '0;
        for (int i = 0; i < AW; i++) brev[i] = load_cnt_q[AW-1-i];
    end

    always_comb begin
        state_d = state_q;
        s_ready = 1'b0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_data  = '0;
        busy    = 1'b0;
        case (state_q)
            LOAD: begin
                s_ready = 1'b1;
                if (s_valid && load_cnt_q == LASTI) state_d = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (bf_last) state_d = DRAIN;
            end
            DRAIN: begin
                busy    = 1'b1;
                m_valid = 1'b1;
                m_last  = (out_cnt_q == LASTI);
                m_data  = inverse_q ? mulmod(mem_q[out_cnt_q], NINV) : mem_q[out_cnt_q];
                if (m_ready && out_cnt_q == LASTI) state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOAD;
            load_cnt_q <= '0;
            out_cnt_q  <= '0;
            base_q     <= '0;
            j_q        <= '0;
            st_q       <= '0;
            w_q        <= DW'(1);
            inverse_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                LOAD: if (s_valid) begin
                    // Counter wraps to 0 after beat N-1 (N is a power of two).
                    load_cnt_q <= load_cnt_q + AW'(1);
                    if (load_cnt_q == '0) inverse_q <= s_inverse;
                    if (load_cnt_q == LASTI) begin
                        base_q <= '0;
                        j_q    <= '0;
                        st_q   <= '0;
                        w_q    <= DW'(1);
                    end
                end
                CALC: begin
                    if (grp_last) begin
                        j_q <= '0;
                        w_q <= DW'(1);
                        if (blk_last) begin
                            base_q <= '0;
                            st_q   <= bf_last ? '0 : st_q + SW'(1);
                        end else begin
                            base_q <= end_w[AW-1:0];
                        end
                    end else begin
                        j_q <= j_q + AW'(1);
                        w_q <= mulmod(w_q, wlen);
                    end
                end
                DRAIN: if (m_ready) out_cnt_q <= out_cnt_q + AW'(1);
                default: ;
            endcase
        end
    end

    // Coefficient buffer: contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (state_q == LOAD && s_valid) begin
            mem_q[brev] <= s_red;
        end else if (state_q == CALC) begin
            mem_q[idx_u] <= sum_r;
            mem_q[idx_v] <= diff_r;
        end
    end
endmodule

// File: tb/tb_ntt_iter_core.sv
// tb_ntt_iter_core
//   Self-checking bench: random polynomials against a direct-sum DFT model
//   mod q, plus directed impulse/all-ones cases, backpressure and resets.
module tb_ntt_iter_core;
    localparam int N  = 16;
    localparam int Q  = 17;
    localparam int DW = 16;

    typedef int poly_t [N];

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          s_valid = 1'b0, s_inverse = 1'b0, m_ready = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready, m_valid, m_last, busy;
    logic [DW-1:0] m_data;

    int n_cmp = 0, n_bad = 0;

    ntt_iter_core #(.N(N), .DATA_WIDTH(DW), .MODULUS(Q), .ROOT(3), .ROOT_INV(6), .N_INV(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_inverse(s_inverse),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pw(input int b, input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % Q;
        return r;
    endfunction

    // X[k] = sum x[n] R^(nk); inverse scales by N^-1 = 16.
    task automatic ref_ntt(input poly_t x, input bit inv, output poly_t y);
        for (int k = 0; k < N; k++) begin
            int acc = 0;
            for (int n = 0; n < N; n++)
                acc = (acc + (x[n] % Q) * pw(inv ? 6 : 3, (n * k) % N)) % Q;
            y[k] = inv ? (acc * 16) % Q : acc;
        end
    endtask

    task automatic send(input poly_t x, input bit inv, input bit gaps);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            while (gaps && $urandom_range(0, 2) == 0) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            check("s_ready_load", s_ready, 1);
            s_valid   = 1'b1;
            s_data    = DW'(x[i]);
            s_inverse = (i == 0) ? inv : 1'($urandom_range(0, 1));
            @(posedge clk);
        end
        #1 s_valid = 1'b0;
    endtask

    task automatic recv(output poly_t y, input bit bp);
        int lat = 0, got = 0, cyc = 0;
        logic [DW-1:0] held = '0;
        bit stalled = 0;
        y = '{default: -1};
        @(negedge clk);
        while (!m_valid && lat < 2000) begin
            check("s_ready_calc", s_ready, 0);
            check("busy_calc", busy, 1);
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 32);
        while (got < N && cyc < 2000) begin
            check("m_valid_drain", m_valid, 1);
            check("s_ready_drain", s_ready, 0);
            if (stalled) check("stall_hold", m_data, held);
            m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_ready) begin
                y[got] = int'(m_data);
                check("m_last", m_last, (got == N-1) ? 1 : 0);
                got++;
                stalled = 0;
            end else begin
                stalled = 1;
                held    = m_data;
            end
            @(negedge clk);
            cyc++;
        end
        m_ready = 1'b0;
        check("drain_count", got, N);
        check("m_valid_idle", m_valid, 0);
        check("s_ready_idle", s_ready, 1);
    endtask

    task automatic cmp_poly(input string tag, input poly_t got, input poly_t exp);
        for (int k = 0; k < N; k++) check(tag, got[k], exp[k]);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_s_ready", s_ready, 1);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_busy", busy, 0);
        check("rst_m_data", m_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        poly_t x, y, z, e;
        int shifted [N] = '{1, 3, 9, 10, 13, 5, 15, 11, 16, 14, 8, 7, 4, 12, 2, 6};
        int w;

        repeat (3) @(negedge clk);
        check("reset_s_ready", s_ready, 1);
        check("reset_m_valid", m_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_m_data", m_data, 0);
        check("reset_m_last", m_last, 0);
        rst_n = 1'b1;

        // Impulse -> all ones
        x = '{default: 0}; x[0] = 1;
        send(x, 0, 0); recv(y, 0);
        for (int k = 0; k < N; k++) check("impulse", y[k], 1);

        // Shifted impulse -> powers of 3
        x = '{default: 0}; x[1] = 1;
        send(x, 0, 0); recv(y, 0);
        for (int k = 0; k < N; k++) check("shifted", y[k], shifted[k]);

        // All ones, forward and inverse
        x = '{default: 1};
        send(x, 0, 0); recv(y, 0);
        for (int k = 0; k < N; k++) check("ones_fwd", y[k], (k == 0) ? 16 : 0);
        send(x, 1, 0); recv(y, 0);
        for (int k = 0; k < N; k++) check("ones_inv", y[k], (k == 0) ? 1 : 0);

        // Random round trips with backpressure and input gaps
        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < N; k++)
                x[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535))
                                                   : int'($urandom_range(0, Q-1));
            if (r < 2) begin x[0] = 17; x[1] = 20; end
            send(x, 0, r[0]); recv(y, r >= 2);
            ref_ntt(x, 0, e);
            cmp_poly("fwd_rand", y, e);
            send(y, 1, r[1]); recv(z, r >= 2);
            for (int k = 0; k < N; k++) e[k] = x[k] % Q;
            cmp_poly("round_trip", z, e);
            if (r < 2) begin
                check("reduce_17", z[0], 0);
                check("reduce_20", z[1], 3);
            end
        end

        // Reset mid-CALC
        x = '{default: 0}; x[0] = 1;
        send(x, 0, 0);
        repeat (10) @(negedge clk);
        check("mid_calc_busy", busy, 1);
        reset_pulse();
        send(x, 0, 0); recv(y, 0);
        for (int k = 0; k < N; k++) check("after_calc_rst", y[k], 1);

        // Reset mid-DRAIN
        x = '{default: 0}; x[3] = 5;
        send(x, 0, 0);
        w = 0;
        @(negedge clk);
        while (!m_valid && w < 2000) begin @(negedge clk); w++; end
        check("drain_reached", m_valid, 1);
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        m_ready = 1'b0;
        reset_pulse();
        x = '{default: 0}; x[0] = 1;
        send(x, 0, 0); recv(y, 0);
        for (int k = 0; k < N; k++) check("after_drain_rst", y[k], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
